// File: rtl/enc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_pkg
// Description : Shared constants and helpers for the quadrature encoder
//               front end: detent phase, clockwise phase order, and the
//               direction encodings reported on the dir output.
// Revision    : 1.0 - initial release
// ============================================================================
package enc_pkg;

    // Rest position of the encoder between detents (both phases high)
    localparam logic [1:0] PH_DETENT = 2'b11;

    // Clockwise phase order starting from the detent: 11 -> 01 -> 00 -> 10
    localparam logic [1:0] CW_ORDER [4] = '{2'b11, 2'b01, 2'b00, 2'b10};

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

    // Position of an AB phase within the clockwise cycle (0..3)
    function automatic logic [1:0] ph_idx(input logic [1:0] ph);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (CW_ORDER[i] == ph) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage : enc_pkg
`default_nettype wire

// File: rtl/enc_debounce.sv
`default_nettype none
// ============================================================================
// Module      : enc_debounce
// Description : Two-flop synchroniser followed by a stability filter. The
//               filtered output only follows the synchronised input after it
//               has disagreed for DEBOUNCE consecutive cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_debounce #(
    parameter int   DEBOUNCE = 50000,
    parameter logic RST_VAL  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_filt
);

    localparam int             CNT_W      = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic [1:0]       r_sync;
    logic             r_filt;
    logic [CNT_W-1:0] r_cnt;

    // Synchronise the raw pin and count consecutive cycles of disagreement
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {RST_VAL, RST_VAL};
            r_filt <= RST_VAL;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (r_sync[1] != r_filt) begin
                if (r_cnt == C_CNT_LAST) begin
                    r_filt <= r_sync[1];
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_filt = r_filt;

endmodule : enc_debounce
`default_nettype wire

// File: rtl/enc_quad_cursor.sv
`default_nettype none
// ============================================================================
// Module      : enc_quad_cursor
// Description : Quadrature rotary-encoder front end. Debounces A/B/switch,
//               decodes full detent steps and maintains a bounded 8-bit
//               position (saturating or wrapping), with button centring.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_quad_cursor
    import enc_pkg::*;
#(
    parameter int MAX_POS       = 159,
    parameter int WRAP          = 0,
    parameter int DEBOUNCE      = 50000,
    parameter int CENTER_ON_BTN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       enc_sw,
    output logic [7:0] pos,
    output logic [1:0] dir,
    output logic       step,
    output logic       btn,
    output logic       err
);

    localparam logic [7:0] C_MAX    = 8'(MAX_POS);
    localparam logic [7:0] C_CENTER = 8'(MAX_POS / 2);

    logic w_a, w_b, w_sw;

    enc_debounce #(.DEBOUNCE(DEBOUNCE), .RST_VAL(1'b1)) u_db_a (
        .clk(clk), .rst(rst), .i_raw(enc_a), .o_filt(w_a)
    );
    enc_debounce #(.DEBOUNCE(DEBOUNCE), .RST_VAL(1'b1)) u_db_b (
        .clk(clk), .rst(rst), .i_raw(enc_b), .o_filt(w_b)
    );
    enc_debounce #(.DEBOUNCE(DEBOUNCE), .RST_VAL(1'b0)) u_db_sw (
        .clk(clk), .rst(rst), .i_raw(enc_sw), .o_filt(w_sw)
    );

    logic [1:0]        r_ab_ref;
    logic              r_sw_prev;
    logic signed [2:0] r_acc;
    logic [7:0]        r_pos;
    dir_e              r_dir;
    logic              r_step, r_btn, r_err;

    logic [1:0]        w_ab, w_idx_diff;
    logic              w_cw, w_ccw, w_bad, w_detent, w_up, w_dn, w_btn_rise;
    logic signed [3:0] w_delta, w_acc_sum;
    logic [8:0]        w_pos_inc, w_pos_dec;
    logic [7:0]        w_pos_next;

    // Classify the filtered phase change and resolve detents. The sum is one
    // bit wider than the accumulator because the final transition into the
    // detent reaches +/-4, which never needs to be stored.
    always_comb begin
        w_ab       = {w_a, w_b};
        w_idx_diff = ph_idx(w_ab) - ph_idx(r_ab_ref);
        w_cw       = (w_idx_diff == 2'd1);
        w_ccw      = (w_idx_diff == 2'd3);
        w_bad      = (w_idx_diff == 2'd2);
        w_delta    = w_cw ? 4'sd1 : (w_ccw ? -4'sd1 : 4'sd0);
        w_acc_sum  = $signed({r_acc[2], r_acc}) + w_delta;
        w_detent   = (w_cw || w_ccw) && (w_ab == PH_DETENT);
        w_up       = w_detent && (w_acc_sum == 4'sd4);
        w_dn       = w_detent && (w_acc_sum == -4'sd4);
        w_btn_rise = w_sw && !r_sw_prev;
    end

    // Next position: bounded step, then a button load overrides it
    always_comb begin
        w_pos_inc  = {1'b0, r_pos} + 9'd1;
        w_pos_dec  = {1'b0, r_pos} - 9'd1;
        w_pos_next = r_pos;
        if (w_up) begin
            if (r_pos == C_MAX) begin
                w_pos_next = (WRAP != 0) ? 8'd0 : r_pos;
            end else begin
                w_pos_next = w_pos_inc[7:0];
            end
        end else if (w_dn) begin
            if (r_pos == 8'd0) begin
                w_pos_next = (WRAP != 0) ? C_MAX : r_pos;
            end else begin
                w_pos_next = w_pos_dec[7:0];
            end
        end
        if (w_btn_rise && (CENTER_ON_BTN != 0)) begin
            w_pos_next = C_CENTER;
        end
    end

    // Phase reference, sub-step accumulator, position and output pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ab_ref  <= PH_DETENT;
            r_sw_prev <= 1'b0;
            r_acc     <= '0;
            r_pos     <= '0;
            r_dir     <= DIR_NONE;
            r_step    <= 1'b0;
            r_btn     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ab_ref  <= w_ab;
            r_sw_prev <= w_sw;
            r_err     <= w_bad;
            r_step    <= w_up || w_dn;
            r_btn     <= w_btn_rise;
            r_pos     <= w_pos_next;
            if (w_up) begin
                r_dir <= DIR_UP;
            end else if (w_dn) begin
                r_dir <= DIR_DOWN;
            end
            if (w_bad || w_detent) begin
                r_acc <= '0;
            end else if (w_cw || w_ccw) begin
                r_acc <= w_acc_sum[2:0];
            end
        end
    end

    assign pos  = r_pos;
    assign dir  = r_dir;
    assign step = r_step;
    assign btn  = r_btn;
    assign err  = r_err;

endmodule : enc_quad_cursor
`default_nettype wire

// File: tb/tb_enc_quad_cursor.sv
`default_nettype none
// ============================================================================
// Module      : tb_enc_quad_cursor
// Description : Directed bench for enc_quad_cursor. Four instances share the
//               encoder stimulus: 159/saturate, 159/wrap, 119/saturate and
//               255/saturate, all with DEBOUNCE=4 and button centring.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_enc_quad_cursor;

    logic       clk = 1'b0;
    logic       rst;
    logic       enc_a, enc_b, enc_sw;
    logic [7:0] pos [4];
    logic [1:0] dir [4];
    logic [3:0] step_v, btn_v, err_v;

    int step_cnt [4];
    int btn_cnt  [4];
    int err_cnt  [4];
    int sb [4];
    int bb [4];
    int eb [4];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    enc_quad_cursor #(.MAX_POS(159), .WRAP(0), .DEBOUNCE(4), .CENTER_ON_BTN(1)) u_dut0 (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
        .pos(pos[0]), .dir(dir[0]), .step(step_v[0]), .btn(btn_v[0]), .err(err_v[0])
    );
    enc_quad_cursor #(.MAX_POS(159), .WRAP(1), .DEBOUNCE(4), .CENTER_ON_BTN(1)) u_dut1 (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
        .pos(pos[1]), .dir(dir[1]), .step(step_v[1]), .btn(btn_v[1]), .err(err_v[1])
    );
    enc_quad_cursor #(.MAX_POS(119), .WRAP(0), .DEBOUNCE(4), .CENTER_ON_BTN(1)) u_dut2 (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
        .pos(pos[2]), .dir(dir[2]), .step(step_v[2]), .btn(btn_v[2]), .err(err_v[2])
    );
    enc_quad_cursor #(.MAX_POS(255), .WRAP(0), .DEBOUNCE(4), .CENTER_ON_BTN(1)) u_dut3 (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw),
        .pos(pos[3]), .dir(dir[3]), .step(step_v[3]), .btn(btn_v[3]), .err(err_v[3])
    );

    // Pulse counters, one per instance and output
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (step_v[i]) step_cnt[i] = step_cnt[i] + 1;
            if (btn_v[i])  btn_cnt[i]  = btn_cnt[i] + 1;
            if (err_v[i])  err_cnt[i]  = err_cnt[i] + 1;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) begin
            sb[i] = step_cnt[i];
            bb[i] = btn_cnt[i];
            eb[i] = err_cnt[i];
        end
    endtask

    task automatic phase(input logic [1:0] ab);
        {enc_a, enc_b} = ab;
        cyc(8);
    endtask

    initial begin
        rst = 1'b1; enc_a = 1'b1; enc_b = 1'b1; enc_sw = 1'b0;
        cyc(4);
        rst = 1'b0;
        #1;
        check_eq("rst_pos0", pos[0], 0);
        check_eq("rst_dir0", dir[0], 0);
        check_eq("rst_pos3", pos[3], 0);
        snap();
        cyc(20);
        check_eq("idle_step", step_cnt[0] - sb[0], 0);
        check_eq("idle_btn",  btn_cnt[0] - bb[0], 0);
        check_eq("idle_err",  err_cnt[0] - eb[0], 0);
        check_eq("idle_pos",  pos[0], 0);

        // One clockwise detent
        snap();
        phase(2'b01); phase(2'b00); phase(2'b10); phase(2'b11); cyc(6);
        check_eq("cw_step", step_cnt[0] - sb[0], 1);
        check_eq("cw_pos",  pos[0], 1);
        check_eq("cw_dir",  dir[0], 1);
        check_eq("cw_err",  err_cnt[0] - eb[0], 0);
        check_eq("cw_pos_wrap", pos[1], 1);

        // Counter-clockwise back to 0, then one more into the lower bound
        phase(2'b10); phase(2'b00); phase(2'b01); phase(2'b11); cyc(6);
        check_eq("ccw_pos", pos[0], 0);
        snap();
        phase(2'b10); phase(2'b00); phase(2'b01); phase(2'b11); cyc(6);
        check_eq("sat_pos",  pos[0], 0);
        check_eq("sat_step", step_cnt[0] - sb[0], 1);
        check_eq("sat_dir",  dir[0], 2);
        check_eq("wrap_pos", pos[1], 159);
        check_eq("wrap_step", step_cnt[1] - sb[1], 1);
        check_eq("sat_err",  err_cnt[0] - eb[0], 0);

        // Short glitch on A from rest
        snap();
        enc_a = 1'b0; cyc(3); enc_a = 1'b1; cyc(20);
        check_eq("glitch_step", step_cnt[0] - sb[0], 0);
        check_eq("glitch_err",  err_cnt[0] - eb[0], 0);
        check_eq("glitch_pos",  pos[1], 159);

        // Half rotation returning to the detent
        snap();
        phase(2'b01); phase(2'b00); phase(2'b01); phase(2'b11); cyc(6);
        check_eq("half_step", step_cnt[0] - sb[0], 0);
        check_eq("half_err",  err_cnt[0] - eb[0], 0);
        check_eq("half_pos",  pos[1], 159);

        // Illegal two-phase jumps
        snap();
        phase(2'b00); cyc(4);
        check_eq("bad_err1", err_cnt[0] - eb[0], 1);
        phase(2'b11); cyc(6);
        check_eq("bad_err2", err_cnt[0] - eb[0], 2);
        check_eq("bad_step", step_cnt[0] - sb[0], 0);

        // Button held 50 cycles
        snap();
        enc_sw = 1'b1; cyc(50); enc_sw = 1'b0; cyc(12);
        check_eq("btn_cnt",   btn_cnt[2] - bb[2], 1);
        check_eq("btn_pos119", pos[2], 59);
        check_eq("btn_pos255", pos[3], 127);
        check_eq("btn_pos159", pos[0], 79);
        check_eq("btn_step",  step_cnt[2] - sb[2], 0);

        // Reset part-way through a clockwise detent
        phase(2'b01); phase(2'b00);
        rst = 1'b1; cyc(3); rst = 1'b0;
        #1;
        check_eq("mid_rst_pos", pos[0], 0);
        check_eq("mid_rst_dir", dir[0], 0);
        snap();
        cyc(8);
        phase(2'b10); phase(2'b11); cyc(8);
        check_eq("mid_rst_step", step_cnt[0] - sb[0], 0);
        check_eq("mid_rst_pos_end", pos[0], 0);
        check_eq("mid_rst_pos3", pos[3], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_enc_quad_cursor
`default_nettype wire
